// File: rtl/sdrx_sample_align.sv
// Multi-lane SD receive sampler: delay-compensated strobe, phase pick, start-bit hunt, framed capture.
// Optional start-bit timeout is compiled in with `define SDRX_TIMEOUT_EN.
module sdrx_sample_align #(
  parameter int unsigned NLANES = 4,
  parameter int unsigned DW     = 4,
  parameter int unsigned LW     = 12,
  parameter int unsigned TW     = 20
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [8*NLANES-1:0]   i_wide,
  input  logic                  i_ckstb,
  input  logic [2:0]            i_ckphase,
  input  logic [DW-1:0]         i_delay,
  input  logic                  i_start,
  input  logic [LW-1:0]         i_len,
  input  logic [TW-1:0]         i_timeout,
  output logic                  o_busy,
  output logic                  o_valid,
  output logic [NLANES-1:0]     o_data,
  output logic                  o_last,
  output logic                  o_done,
  output logic                  o_err
);

  localparam int unsigned DEPTH = (1 << DW) - 1;

  typedef enum logic [1:0] {IDLE, HUNT, DATA, DONE} state_t;

  logic [3:0]        dline [DEPTH];
  logic [3:0]        tap;
  logic [DW-1:0]     tap_idx;
  logic [2:0]        bit_sel;
  logic [7:0]        lane_word;
  logic [NLANES-1:0] smp_next;
  logic              smp_valid;
  logic [NLANES-1:0] smp_data;

  state_t            state, state_n;
  logic [LW-1:0]     cnt, cnt_n;
  logic [LW-1:0]     len_q, len_n;
  logic              err_q, err_q_n;
  logic              busy_n, valid_n, last_n, done_n, err_n;
  logic [NLANES-1:0] data_n;

  // Strobe and its phase travel together so a delayed strobe keeps its own phase.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) dline[i] <= '0;
    end else begin
      dline[0] <= {i_ckstb, i_ckphase};
      for (int unsigned i = 1; i < DEPTH; i++) dline[i] <= dline[i-1];
    end
  end

  always_comb begin
    tap_idx   = i_delay - 1'b1;
    tap       = (i_delay == '0) ? {i_ckstb, i_ckphase} : dline[tap_idx];
    bit_sel   = ~tap[2:0];
    smp_next  = '0;
    lane_word = '0;
    for (int unsigned n = 0; n < NLANES; n++) begin
      lane_word   = i_wide[8*n +: 8];
      smp_next[n] = lane_word[bit_sel];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      smp_valid <= 1'b0;
      smp_data  <= '0;
    end else begin
      smp_valid <= tap[3];
      if (tap[3]) smp_data <= smp_next;
    end
  end

`ifdef SDRX_TIMEOUT_EN
  logic [TW-1:0] tmo_q, tmo_n;
  logic [TW-1:0] tcnt, tcnt_n;
`else
  logic unused_timeout;
  assign unused_timeout = ^i_timeout;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    len_n   = len_q;
    err_q_n = err_q;
    valid_n = 1'b0;
    data_n  = o_data;
    last_n  = 1'b0;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef SDRX_TIMEOUT_EN
    tmo_n   = tmo_q;
    tcnt_n  = tcnt;
`endif
    unique case (state)
      IDLE: begin
        // o_busy still reads 1 during the o_done clock, so a start there is ignored too.
        if (i_start && !o_busy) begin
          state_n = HUNT;
          len_n   = i_len;
          err_q_n = 1'b0;
`ifdef SDRX_TIMEOUT_EN
          tmo_n   = i_timeout;
          tcnt_n  = '0;
`endif
        end
      end
      HUNT: begin
        if (smp_valid && !smp_data[0]) begin
          cnt_n   = len_q;
          state_n = (len_q == '0) ? DONE : DATA;
        end
`ifdef SDRX_TIMEOUT_EN
        else if (tmo_q != '0 && tcnt == tmo_q) begin
          state_n = DONE;
          err_q_n = 1'b1;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
`endif
      end
      DATA: begin
        if (smp_valid) begin
          valid_n = 1'b1;
          data_n  = smp_data;
          cnt_n   = cnt - 1'b1;
          if (cnt == LW'(1)) begin
            last_n  = 1'b1;
            state_n = DONE;
          end
        end
      end
      DONE: begin
        done_n  = 1'b1;
        err_n   = err_q;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE) || done_n;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
      o_busy  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
      o_done  <= 1'b0;
      o_err   <= 1'b0;
`ifdef SDRX_TIMEOUT_EN
      tmo_q   <= '0;
      tcnt    <= '0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      len_q   <= len_n;
      err_q   <= err_q_n;
      o_busy  <= busy_n;
      o_valid <= valid_n;
      o_data  <= data_n;
      o_last  <= last_n;
      o_done  <= done_n;
      o_err   <= err_n;
`ifdef SDRX_TIMEOUT_EN
      tmo_q   <= tmo_n;
      tcnt    <= tcnt_n;
`endif
    end
  end

endmodule

// File: tb/tb_sdrx_sample_align.sv
// Directed bench for sdrx_sample_align: vector table for delay/phase selection plus capture sequences.
module tb_sdrx_sample_align;

  localparam int NL = 4;
  localparam int DW = 4;
  localparam int LW = 12;
  localparam int TW = 20;

  logic            clk = 1'b0;
  logic            i_reset;
  logic [8*NL-1:0] i_wide;
  logic            i_ckstb;
  logic [2:0]      i_ckphase;
  logic [DW-1:0]   i_delay;
  logic            i_start;
  logic [LW-1:0]   i_len;
  logic [TW-1:0]   i_timeout;
  logic            o_busy, o_valid, o_last, o_done, o_err;
  logic [NL-1:0]   o_data;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdrx_sample_align #(.NLANES(NL), .DW(DW), .LW(LW), .TW(TW)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_wide(i_wide), .i_ckstb(i_ckstb),
    .i_ckphase(i_ckphase), .i_delay(i_delay), .i_start(i_start), .i_len(i_len),
    .i_timeout(i_timeout), .o_busy(o_busy), .o_valid(o_valid), .o_data(o_data),
    .o_last(o_last), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {
    int          d;
    logic [2:0]  ph;
    logic [31:0] wide;
    logic [3:0]  exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    i_ckstb = 1'b0;
    i_wide  = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic arm(input int len);
    i_len   = LW'(len);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
  endtask

  initial begin
    int vcyc, dcyc, beats, lastbeat, dones, n;
    logic [3:0] vdata;
    logic vlast;

    vecs[0] = '{d: 0,  ph: 3'd3, wide: 32'hEF_FF_00_10, exp_data: 4'h5};
    vecs[1] = '{d: 5,  ph: 3'd0, wide: 32'h80_80_7F_80, exp_data: 4'hD};
    vecs[2] = '{d: 5,  ph: 3'd7, wide: 32'h01_FE_FE_01, exp_data: 4'h9};
    vecs[3] = '{d: 15, ph: 3'd5, wide: 32'h04_FB_04_04, exp_data: 4'hB};
    vecs[4] = '{d: 2,  ph: 3'd1, wide: 32'h00_00_40_40, exp_data: 4'h3};

    i_reset = 1'b1; i_wide = '0; i_ckstb = 1'b0; i_ckphase = '0; i_delay = '0;
    i_start = 1'b0; i_len = '0; i_timeout = '0;
    step(); step(); step();
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_last", o_last, 0);
    chk("rst_done", o_done, 0);
    chk("rst_err", o_err, 0);
    i_reset = 1'b0;

    // Table: start-bit strobe then one data strobe on the next clock, i_len=1.
    for (int v = 0; v < 5; v++) begin
      i_delay   = DW'(vecs[v].d);
      i_ckphase = vecs[v].ph;
      idle(17);
      arm(1);
      chk("vec_busy", o_busy, 1);
      vcyc = -1; dcyc = -1; vdata = '0; vlast = 1'b0;
      for (int k = 0; k < vecs[v].d + 7; k++) begin
        i_ckstb = (k < 2);
        i_wide  = (k <= vecs[v].d) ? 32'h0 : vecs[v].wide;
        step();
        if (o_valid && vcyc < 0) begin vcyc = k + 1; vdata = o_data; vlast = o_last; end
        if (o_done && dcyc < 0) dcyc = k + 1;
      end
      chk($sformatf("vec%0d_latency", v), vcyc, vecs[v].d + 3);
      chk($sformatf("vec%0d_data", v), vdata, vecs[v].exp_data);
      chk($sformatf("vec%0d_last", v), vlast, 1);
      chk($sformatf("vec%0d_done", v), dcyc, vecs[v].d + 4);
    end

    // Basic capture: strobe every 4 clocks, pattern 1010 on all lanes, i_len=4.
    i_delay = '0; i_ckphase = 3'd3;
    idle(17);
    arm(4);
    for (int k = 0; k < 22; k++) begin
      int c;
      i_ckstb = (k % 4 == 0) && (k <= 16);
      case (k)
        4, 12:   i_wide = 32'h10101010;
        default: i_wide = 32'h0;
      endcase
      step();
      c = k + 1;
      chk("basic_valid", o_valid, int'(c == 6 || c == 10 || c == 14 || c == 18));
      chk("basic_last", o_last, int'(c == 18));
      chk("basic_done", o_done, int'(c == 19));
      chk("basic_busy", o_busy, int'(c <= 19));
      if (c == 6 || c == 14) chk("basic_data", o_data, 4'hF);
      if (c == 10 || c == 18) chk("basic_data", o_data, 4'h0);
      if (c == 19) chk("basic_err", o_err, 0);
    end

    // Zero length: done two clocks after the start-bit strobe is sampled, no beats.
    i_ckphase = 3'd0;
    idle(4);
    arm(0);
    dcyc = -1; beats = 0;
    for (int k = 0; k < 8; k++) begin
      i_ckstb = (k == 0);
      i_wide  = 32'h0;
      step();
      if (o_valid) beats++;
      if (o_done && dcyc < 0) dcyc = k + 1;
    end
    chk("zero_beats", beats, 0);
    chk("zero_done", dcyc, 3);

    // Reset after 2 of 8 beats.
    idle(4);
    arm(8);
    beats = 0;
    for (int k = 0; k < 4; k++) begin
      i_ckstb = 1'b1;
      i_wide  = (k == 0) ? 32'h0 : 32'h80808080;
      step();
      if (o_valid) beats++;
    end
    chk("rst_mid_beats", beats, 2);
    i_reset = 1'b1;
    step();
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_valid", o_valid, 0);
    chk("rst_mid_data", o_data, 0);
    chk("rst_mid_last", o_last, 0);
    chk("rst_mid_done", o_done, 0);
    i_reset = 1'b0;
    i_ckstb = 1'b0;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (o_done) dones++;
    end
    chk("rst_mid_no_done", dones, 0);

    // Re-arm: a second start with i_len=2 mid-capture must be ignored.
    arm(8);
    beats = 0; lastbeat = -1; dones = 0;
    for (int k = 0; k < 30; k++) begin
      i_ckstb = (k <= 8);
      i_wide  = (k % 2 == 1) ? 32'h80808080 : 32'h0;
      i_start = (k == 4);
      i_len   = (k == 4) ? LW'(2) : LW'(8);
      step();
      if (o_valid) begin
        beats++;
        chk("rearm_data", o_data, (beats % 2 == 1) ? 4'hF : 4'h0);
        if (o_last) lastbeat = beats;
      end
      if (o_done) dones++;
    end
    i_start = 1'b0;
    chk("rearm_beats", beats, 8);
    chk("rearm_lastbeat", lastbeat, 8);
    chk("rearm_done", dones, 1);

    // Lane 0 held high: no start bit ever arrives.
    idle(4);
    i_timeout = TW'(100);
    arm(4);
    n = 1;
`ifdef SDRX_TIMEOUT_EN
    dcyc = -1;
    i_ckstb = 1'b1;
    i_wide  = '1;
    while (n < 250 && dcyc < 0) begin
      step();
      n++;
      if (o_done) begin dcyc = n; vlast = o_err; end
    end
    chk("tmo_done_cycle", dcyc, 103);
    chk("tmo_err", vlast, 1);
`else
    dones = 0;
    i_ckstb = 1'b1;
    i_wide  = '1;
    for (int k = 0; k < 150; k++) begin
      step();
      if (o_done) dones++;
    end
    chk("hunt_busy", o_busy, 1);
    chk("hunt_no_done", dones, 0);
`endif
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    chk("final_busy", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
